// File: rtl/seq_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_arbiter_if                                                             |
// | Requester and machine-pin bundle for the two-requester burst arbiter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface seq_arbiter_if #(
  parameter int LEN = 4
);
  logic           REQ0;
  logic           REQ1;
  logic           A0;
  logic           B0;
  logic           A1;
  logic           B1;
  logic           GNT0;
  logic           GNT1;
  logic           MA;
  logic           MB;
  logic           MY;
  logic           MZ;
  logic [LEN-1:0] RESY;
  logic [LEN-1:0] RESZ;
  logic           OWN;
  logic           DONE;

  // Master is the environment: both requesters plus the shared machine.
  modport master (
    output REQ0, REQ1, A0, B0, A1, B1, MY, MZ,
    input  GNT0, GNT1, MA, MB, RESY, RESZ, OWN, DONE
  );

  modport slave (
    input  REQ0, REQ1, A0, B0, A1, B1, MY, MZ,
    output GNT0, GNT1, MA, MB, RESY, RESZ, OWN, DONE
  );
endinterface
`default_nettype wire

// File: rtl/seq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_arbiter                                                                |
// | Round-robin sharing of one registered A/B -> Y/Z machine between two       |
// | requesters; captures a LEN-sample response burst and pulses DONE.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_arbiter #(
  parameter int LEN = 4,
  parameter int CW  = 4
) (
  input  wire logic    CLK,
  input  wire logic    RST,
  seq_arbiter_if.slave bus
);

  localparam logic [1:0]    S_IDLE  = 2'd0;
  localparam logic [1:0]    S_BURST = 2'd1;
  localparam logic [1:0]    S_FLUSH = 2'd2;
  localparam logic [CW-1:0] C_LAST  = CW'(LEN - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ptr_q, ptr_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           own_q, own_d;
  logic           done_q, done_d;
  logic [LEN-1:0] resy_q, resy_d;
  logic [LEN-1:0] resz_q, resz_d;

  logic           pick;
  logic           capture;
  logic [LEN-1:0] resy_shift;
  logic [LEN-1:0] resz_shift;

  // A one-bit result register has nothing to shift down; it just reloads.
  generate
    if (LEN > 1) begin : g_shift_multi
      assign resy_shift = {bus.MY, resy_q[LEN-1:1]};
      assign resz_shift = {bus.MZ, resz_q[LEN-1:1]};
    end else begin : g_shift_single
      assign resy_shift = bus.MY;
      assign resz_shift = bus.MZ;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    own_d   = own_q;
    done_d  = 1'b0;
    pick    = 1'b0;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          pick    = (bus.REQ0 && bus.REQ1) ? ptr_q : bus.REQ1;
          state_d = S_BURST;
          cnt_d   = '0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          own_d   = pick;
        end
      end

      S_BURST: begin
        // The machine is one cycle behind the stimulus, so the first
        // burst cycle has no response to sample yet.
        cnt_d   = cnt_q + C_ONE;
        capture = (cnt_q != '0);
        if (cnt_q == C_LAST) begin
          state_d = S_FLUSH;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          ptr_d   = ~own_q;
        end
      end

      S_FLUSH: begin
        capture = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase

    resy_d = capture ? resy_shift : resy_q;
    resz_d = capture ? resz_shift : resz_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      own_q   <= 1'b0;
      done_q  <= 1'b0;
      resy_q  <= '0;
      resz_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      own_q   <= own_d;
      done_q  <= done_d;
      resy_q  <= resy_d;
      resz_q  <= resz_d;
    end
  end

  assign bus.GNT0 = gnt0_q;
  assign bus.GNT1 = gnt1_q;
  assign bus.MA   = (gnt0_q & bus.A0) | (gnt1_q & bus.A1);
  assign bus.MB   = (gnt0_q & bus.B0) | (gnt1_q & bus.B1);
  assign bus.RESY = resy_q;
  assign bus.RESZ = resz_q;
  assign bus.OWN  = own_q;
  assign bus.DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_arbiter                                                             |
// | Scoreboard bench for seq_arbiter (LEN=4 and LEN=1) with delay-stub machine.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seq_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 CLK = ~CLK;

  seq_arbiter_if #(.LEN(4)) b4 ();
  seq_arbiter_if #(.LEN(1)) b1 ();

  seq_arbiter #(.LEN(4), .CW(4)) u4 (.CLK(CLK), .RST(RST), .bus(b4));
  seq_arbiter #(.LEN(1), .CW(1)) u1 (.CLK(CLK), .RST(RST), .bus(b1));

  // Machine stub: Y/Z are A/B delayed by one cycle.
  always @(posedge CLK) begin
    b4.MY <= b4.MA;
    b4.MZ <= b4.MB;
    b1.MY <= b1.MA;
    b1.MZ <= b1.MB;
  end

  typedef struct packed {
    logic       own;
    logic [3:0] y;
    logic [3:0] z;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  logic [3:0] s0a, s0b, s1a, s1b;
  logic       t0a, t0b, t1a, t1b;
  int         k0 = 0;
  int         k1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Requester stimulus drivers; ungranted requesters present junk ones.
  always @(negedge CLK) begin
    if (b4.GNT0) begin
      b4.A0 = s0a[k0[1:0]]; b4.B0 = s0b[k0[1:0]]; k0++;
    end else begin
      k0 = 0; b4.A0 = 1'b1; b4.B0 = 1'b1;
    end
    if (b4.GNT1) begin
      b4.A1 = s1a[k1[1:0]]; b4.B1 = s1b[k1[1:0]]; k1++;
    end else begin
      k1 = 0; b4.A1 = 1'b1; b4.B1 = 1'b1;
    end
    b1.A0 = b1.GNT0 ? t0a : 1'b1;
    b1.B0 = b1.GNT0 ? t0b : 1'b1;
    b1.A1 = b1.GNT1 ? t1a : 1'b1;
    b1.B1 = b1.GNT1 ? t1b : 1'b1;
  end

  // Monitor / scoreboard, sampling 1 ns after each rising edge.
  int   g4 = 0, h4 = 0, g1 = 0, h1 = 0;
  logic gp4 = 1'b0, gp1 = 1'b0, gn4, gn1;
  exp_t e;

  always begin
    @(posedge CLK);
    #1;
    cyc++;
    if (RST) begin
      h4 = 0; gp4 = 1'b0; h1 = 0; gp1 = 1'b0;
    end else begin
      gn4 = b4.GNT0 | b4.GNT1;
      chk("gnt_overlap4", 32'(b4.GNT0 & b4.GNT1), 0);
      if (!gn4) begin
        chk("ma_idle4", 32'(b4.MA), 0);
        chk("mb_idle4", 32'(b4.MB), 0);
      end
      if (gn4 && !gp4) begin g4 = cyc; h4 = 0; end
      if (gn4) h4++;
      if (!gn4 && gp4) chk("gnt_len4", h4, 4);
      gp4 = gn4;
      if (b4.DONE) begin
        if (q4.size() == 0) begin
          errors++; checks++;
          $display("FAIL done4_unexpected: got DONE=1, required DONE=0");
        end else begin
          e = q4.pop_front();
          chk("own4", 32'(b4.OWN), 32'(e.own));
          chk("resy4", 32'(b4.RESY), 32'(e.y));
          chk("resz4", 32'(b4.RESZ), 32'(e.z));
          chk("done_lat4", cyc - g4, 5);
        end
      end

      gn1 = b1.GNT0 | b1.GNT1;
      chk("gnt_overlap1", 32'(b1.GNT0 & b1.GNT1), 0);
      if (!gn1) chk("ma_idle1", 32'({b1.MA, b1.MB}), 0);
      if (gn1 && !gp1) begin g1 = cyc; h1 = 0; end
      if (gn1) h1++;
      if (!gn1 && gp1) chk("gnt_len1", h1, 1);
      gp1 = gn1;
      if (b1.DONE) begin
        if (q1.size() == 0) begin
          errors++; checks++;
          $display("FAIL done1_unexpected: got DONE=1, required DONE=0");
        end else begin
          e = q1.pop_front();
          chk("own1", 32'(b1.OWN), 32'(e.own));
          chk("resy1", 32'(b1.RESY), 32'(e.y));
          chk("resz1", 32'(b1.RESZ), 32'(e.z));
          chk("done_lat1", cyc - g1, 2);
        end
      end
    end
  end

  task automatic push4(input logic own, input logic [3:0] y, input logic [3:0] z);
    q4.push_back({own, y, z});
  endtask

  task automatic push1(input logic own, input logic y, input logic z);
    q1.push_back({own, 3'b000, y, 3'b000, z});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge CLK); n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL idle_timeout: got %0d/%0d results outstanding, required 0", q4.size(), q1.size());
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic wait_done4();
    int n = 0;
    while (!b4.DONE && n < 30) begin
      @(negedge CLK); n++;
    end
    if (n >= 30) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no DONE, required DONE within 30 cycles");
    end
  endtask

  task automatic wait_gnt4(input logic which);
    int n = 0;
    while ((which ? !b4.GNT1 : !b4.GNT0) && n < 30) begin
      @(negedge CLK); n++;
    end
    if (n >= 30) begin
      errors++; checks++;
      $display("FAIL gnt_timeout: got no GNT%0d, required GNT within 30 cycles", which);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt"},  32'({b4.GNT0, b4.GNT1, b1.GNT0, b1.GNT1}), 0);
    chk({tag, "_mab"},  32'({b4.MA, b4.MB, b1.MA, b1.MB}), 0);
    chk({tag, "_resy"}, 32'(b4.RESY), 0);
    chk({tag, "_resz"}, 32'(b4.RESZ), 0);
    chk({tag, "_own"},  32'({b4.OWN, b1.OWN}), 0);
    chk({tag, "_done"}, 32'({b4.DONE, b1.DONE}), 0);
  endtask

  initial begin
    RST = 1'b1;
    b4.REQ0 = 1'b0; b4.REQ1 = 1'b0; b1.REQ0 = 1'b0; b1.REQ1 = 1'b0;
    b4.A0 = 1'b0; b4.B0 = 1'b0; b4.A1 = 1'b0; b4.B1 = 1'b0;
    b1.A0 = 1'b0; b1.B0 = 1'b0; b1.A1 = 1'b0; b1.B1 = 1'b0;
    s0a = '0; s0b = '0; s1a = '0; s1b = '0;
    t0a = 1'b0; t0b = 1'b0; t1a = 1'b0; t1b = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_state("rst");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single REQ0 burst.
    s0a = 4'b1101; s0b = 4'b0100;
    push4(1'b0, 4'b1101, 4'b0100);
    b4.REQ0 = 1'b1; @(negedge CLK); b4.REQ0 = 1'b0;
    wait_idle();

    // Both requests held from reset: grants alternate 0,1,0,1 back to back.
    s0a = 4'b0110; s0b = 4'b1001; s1a = 4'b0011; s1b = 4'b1110;
    RST = 1'b1; b4.REQ0 = 1'b1; b4.REQ1 = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    push4(1'b0, 4'b0110, 4'b1001); push4(1'b1, 4'b0011, 4'b1110);
    push4(1'b0, 4'b0110, 4'b1001); push4(1'b1, 4'b0011, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      wait_done4();
      @(negedge CLK);
      chk("b2b_gnt", 32'({b4.GNT1, b4.GNT0}), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    b4.REQ0 = 1'b0; b4.REQ1 = 1'b0;
    wait_idle();

    // REQ1 pulsed once, then REQ0 raised mid-burst and held.
    s1a = 4'b1010; s1b = 4'b0111; s0a = 4'b1001; s0b = 4'b0011;
    push4(1'b1, 4'b1010, 4'b0111); push4(1'b0, 4'b1001, 4'b0011);
    b4.REQ1 = 1'b1; @(negedge CLK); b4.REQ1 = 1'b0;
    wait_gnt4(1'b1);
    @(negedge CLK);
    b4.REQ0 = 1'b1;
    wait_done4();
    chk("gnt0_held", 32'(b4.GNT0), 0);
    @(negedge CLK);
    chk("gnt0_after_done", 32'(b4.GNT0), 1);
    b4.REQ0 = 1'b0;
    wait_idle();

    // Reset in the cnt==2 cycle of a REQ1 burst discards it.
    s1a = 4'b1111; s1b = 4'b1111;
    b4.REQ1 = 1'b1; @(negedge CLK); b4.REQ1 = 1'b0;
    wait_gnt4(1'b1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset_state("midrst");
    repeat (8) @(negedge CLK);
    s0a = 4'b0101; s0b = 4'b1010;
    push4(1'b0, 4'b0101, 4'b1010);
    b4.REQ0 = 1'b1; @(negedge CLK); b4.REQ0 = 1'b0;
    wait_idle();

    // LEN=1 instance: two single-sample bursts.
    t0a = 1'b1; t0b = 1'b1;
    push1(1'b0, 1'b1, 1'b1);
    b1.REQ0 = 1'b1; @(negedge CLK); b1.REQ0 = 1'b0;
    wait_idle();
    t1a = 1'b0; t1b = 1'b1;
    push1(1'b1, 1'b0, 1'b1);
    b1.REQ1 = 1'b1; @(negedge CLK); b1.REQ1 = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
